// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter: shares one memory port between the fetch (I)
// and data (D) sides with one transaction in flight and round-robin tie-breaking.
module mem_arbiter (
    input  logic        clock,
    input  logic        reset,

    input  logic        imem_valid,
    input  logic        imem_instr,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    input  logic [3:0]  imem_wstrb,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,

    input  logic        dmem_valid,
    input  logic        dmem_instr,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,

    output logic        memory_valid,
    output logic        memory_instr,
    output logic [31:0] memory_addr,
    output logic [31:0] memory_wdata,
    output logic [3:0]  memory_wstrb,
    input  logic [31:0] memory_rdata,
    input  logic        memory_ready
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D
    } state_t;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    state_t state_q;
    logic   last_dm_q;           // 1 when D completed the most recent transaction
    logic   pend_im_q;
    logic   pend_dm_q;
    req_t   preq_im_q;
    req_t   preq_dm_q;
    logic   mem_valid_q;
    req_t   mem_req_q;

    req_t   in_im;
    req_t   in_dm;
    req_t   sel_im;
    req_t   sel_dm;
    logic   acc_im;
    logic   acc_dm;
    logic   cand_im;
    logic   cand_dm;

    assign in_im = {imem_instr, imem_addr, imem_wdata, imem_wstrb};
    assign in_dm = {dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb};

    // A fresh valid only counts when the port has nothing pending and is not being served.
    always_comb begin
        acc_im  = imem_valid && !pend_im_q && (state_q != GRANT_I);
        acc_dm  = dmem_valid && !pend_dm_q && (state_q != GRANT_D);
        cand_im = pend_im_q || acc_im;
        cand_dm = pend_dm_q || acc_dm;
        sel_im  = pend_im_q ? preq_im_q : in_im;
        sel_dm  = pend_dm_q ? preq_dm_q : in_dm;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_dm_q   <= 1'b0;
            pend_im_q   <= 1'b0;
            pend_dm_q   <= 1'b0;
            preq_im_q   <= '0;
            preq_dm_q   <= '0;
            mem_valid_q <= 1'b0;
            mem_req_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cand_im && (!cand_dm || last_dm_q)) begin
                        state_q     <= GRANT_I;
                        mem_valid_q <= 1'b1;
                        mem_req_q   <= sel_im;
                        pend_im_q   <= 1'b0;
                        if (acc_dm) begin
                            pend_dm_q <= 1'b1;
                            preq_dm_q <= in_dm;
                        end
                    end else if (cand_dm) begin
                        state_q     <= GRANT_D;
                        mem_valid_q <= 1'b1;
                        mem_req_q   <= sel_dm;
                        pend_dm_q   <= 1'b0;
                        if (acc_im) begin
                            pend_im_q <= 1'b1;
                            preq_im_q <= in_im;
                        end
                    end
                end

                GRANT_I: begin
                    if (memory_ready) begin
                        last_dm_q <= 1'b0;
                        if (cand_dm) begin
                            state_q   <= GRANT_D;
                            mem_req_q <= sel_dm;
                            pend_dm_q <= 1'b0;
                        end else begin
                            state_q     <= IDLE;
                            mem_valid_q <= 1'b0;
                            mem_req_q   <= '0;
                        end
                    end else if (acc_dm) begin
                        pend_dm_q <= 1'b1;
                        preq_dm_q <= in_dm;
                    end
                end

                GRANT_D: begin
                    if (memory_ready) begin
                        last_dm_q <= 1'b1;
                        if (cand_im) begin
                            state_q   <= GRANT_I;
                            mem_req_q <= sel_im;
                            pend_im_q <= 1'b0;
                        end else begin
                            state_q     <= IDLE;
                            mem_valid_q <= 1'b0;
                            mem_req_q   <= '0;
                        end
                    end else if (acc_im) begin
                        pend_im_q <= 1'b1;
                        preq_im_q <= in_im;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    mem_valid_q <= 1'b0;
                    mem_req_q   <= '0;
                end
            endcase
        end
    end

    assign memory_valid = mem_valid_q;
    assign memory_instr = mem_req_q.instr;
    assign memory_addr  = mem_req_q.addr;
    assign memory_wdata = mem_req_q.wdata;
    assign memory_wstrb = mem_req_q.wstrb;

    assign imem_ready = memory_ready && (state_q == GRANT_I);
    assign dmem_ready = memory_ready && (state_q == GRANT_D);
    assign imem_rdata = (state_q == GRANT_I) ? memory_rdata : '0;
    assign dmem_rdata = (state_q == GRANT_D) ? memory_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random
// requesters and memory checked every cycle against a waiting-list reference model.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_valid = 1'b0, imem_instr = 1'b0;
    logic [31:0] imem_addr = '0, imem_wdata = '0;
    logic [3:0]  imem_wstrb = '0;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        dmem_valid = 1'b0, dmem_instr = 1'b0;
    logic [31:0] dmem_addr = '0, dmem_wdata = '0;
    logic [3:0]  dmem_wstrb = '0;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        memory_valid, memory_instr;
    logic [31:0] memory_addr, memory_wdata;
    logic [3:0]  memory_wstrb;
    logic [31:0] memory_rdata = '0;
    logic        memory_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter dut (
        .clock(clock), .reset(reset),
        .imem_valid(imem_valid), .imem_instr(imem_instr), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_wstrb(imem_wstrb),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .memory_valid(memory_valid), .memory_instr(memory_instr), .memory_addr(memory_addr),
        .memory_wdata(memory_wdata), .memory_wstrb(memory_wstrb),
        .memory_rdata(memory_rdata), .memory_ready(memory_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each port holds at most one waiting request; the owner is
    // the port currently presented on the memory port.
    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } rq_t;

    bit  m_busy;
    int  m_own;
    int  m_last;
    rq_t m_cur;
    bit  m_wait [2];
    rq_t m_wreq [2];

    task automatic model_reset();
        m_busy = 0; m_own = 0; m_last = 0; m_cur = '0;
        for (int p = 0; p < 2; p++) begin
            m_wait[p] = 0;
            m_wreq[p] = '0;
        end
    endtask

    task automatic model_step();
        bit  cand [2];
        rq_t creq [2];
        bit  inv  [2];
        int  pick;
        inv[0]  = imem_valid;
        inv[1]  = dmem_valid;
        creq[0] = {imem_instr, imem_addr, imem_wdata, imem_wstrb};
        creq[1] = {dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb};
        for (int p = 0; p < 2; p++) begin
            cand[p] = m_wait[p] || (inv[p] && !(m_busy && m_own == p));
            if (m_wait[p]) creq[p] = m_wreq[p];
        end
        if (m_busy) begin
            if (memory_ready) begin
                m_last = m_own;
                m_busy = 0;
                pick   = 1 - m_own;
                if (cand[pick]) begin
                    m_busy = 1; m_own = pick; m_cur = creq[pick]; cand[pick] = 0;
                end
            end
        end else begin
            if (cand[0] && cand[1]) pick = 1 - m_last;
            else if (cand[0])       pick = 0;
            else if (cand[1])       pick = 1;
            else                    pick = -1;
            if (pick >= 0) begin
                m_busy = 1; m_own = pick; m_cur = creq[pick]; cand[pick] = 0;
            end
        end
        for (int p = 0; p < 2; p++) begin
            m_wait[p] = cand[p];
            if (cand[p]) m_wreq[p] = creq[p];
        end
        if (!m_busy) m_cur = '0;
    endtask

    function automatic bit exp_ready(input int p);
        return m_busy && (m_own == p) && memory_ready;
    endfunction

    function automatic logic [31:0] exp_rdata(input int p);
        return (m_busy && m_own == p) ? memory_rdata : 32'h0;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) model_reset();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            check("m_valid", {31'b0, memory_valid}, {31'b0, m_busy});
            check("m_instr", {31'b0, memory_instr}, {31'b0, m_cur.instr});
            check("m_addr",  memory_addr,  m_cur.addr);
            check("m_wdata", memory_wdata, m_cur.wdata);
            check("m_wstrb", {28'b0, memory_wstrb}, {28'b0, m_cur.wstrb});
            check("i_ready", {31'b0, imem_ready}, {31'b0, exp_ready(0)});
            check("d_ready", {31'b0, dmem_ready}, {31'b0, exp_ready(1)});
            check("i_rdata", imem_rdata, exp_rdata(0));
            check("d_rdata", dmem_rdata, exp_rdata(1));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        imem_valid = 0; imem_instr = 0; imem_addr = '0; imem_wdata = '0; imem_wstrb = '0;
        dmem_valid = 0; dmem_instr = 0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
        memory_ready = 0; memory_rdata = '0;
    endtask

    task automatic rand_port(input int p, input bit en);
        if (p == 0) begin
            imem_valid = en; imem_instr = 1'($urandom); imem_addr = $urandom;
            imem_wdata = $urandom; imem_wstrb = 4'($urandom);
        end else begin
            dmem_valid = en; dmem_instr = 1'($urandom); dmem_addr = $urandom;
            dmem_wdata = $urandom; dmem_wstrb = 4'($urandom);
        end
    endtask

    bit outst [2];

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_valid", {31'b0, memory_valid}, 32'h0);
        check("rst_addr", memory_addr, 32'h0);

        // Single read on I, ready two cycles after memory_valid
        step(); reset = 1;
        imem_valid = 1; imem_instr = 1; imem_addr = 32'h0000_0100; imem_wstrb = 4'h0;
        @(negedge clock);
        check("rd_c0_valid", {31'b0, memory_valid}, 32'h0);
        step(); imem_valid = 0;
        @(negedge clock);
        check("rd_c1_valid", {31'b0, memory_valid}, 32'h1);
        check("rd_c1_addr", memory_addr, 32'h100);
        check("rd_c1_instr", {31'b0, memory_instr}, 32'h1);
        step();
        @(negedge clock);
        check("rd_c2_iready", {31'b0, imem_ready}, 32'h0);
        step(); memory_ready = 1; memory_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        check("rd_c3_iready", {31'b0, imem_ready}, 32'h1);
        check("rd_c3_irdata", imem_rdata, 32'hDEAD_BEEF);
        check("rd_c3_dready", {31'b0, dmem_ready}, 32'h0);
        step(); memory_ready = 0;
        @(negedge clock);
        check("rd_c4_valid", {31'b0, memory_valid}, 32'h0);
        check("rd_c4_addr", memory_addr, 32'h0);

        // Simultaneous requests right after reset: D first, then I back-to-back
        step(); reset = 0;
        step(); reset = 1;
        imem_valid = 1; imem_instr = 1; imem_addr = 32'h10; imem_wstrb = 4'h0;
        dmem_valid = 1; dmem_instr = 0; dmem_addr = 32'h20; dmem_wstrb = 4'hF; dmem_wdata = 32'h1234_5678;
        step(); imem_valid = 0; dmem_valid = 0;
        @(negedge clock);
        check("sim_d_addr", memory_addr, 32'h20);
        check("sim_d_wstrb", {28'b0, memory_wstrb}, 32'hF);
        check("sim_d_wdata", memory_wdata, 32'h1234_5678);
        step(); memory_ready = 1; memory_rdata = 32'h5555_0000;
        @(negedge clock);
        check("sim_d_ready", {31'b0, dmem_ready}, 32'h1);
        check("sim_i_notready", {31'b0, imem_ready}, 32'h0);
        step(); memory_ready = 0;
        @(negedge clock);
        check("sim_b2b_valid", {31'b0, memory_valid}, 32'h1);
        check("sim_b2b_addr", memory_addr, 32'h10);
        step(); memory_ready = 1;
        @(negedge clock);
        check("sim_i_ready", {31'b0, imem_ready}, 32'h1);
        step(); memory_ready = 0;

        // Spurious memory_ready while idle
        step(); memory_ready = 1; memory_rdata = 32'hCAFE_F00D;
        @(negedge clock);
        check("spur_iready", {31'b0, imem_ready}, 32'h0);
        check("spur_dready", {31'b0, dmem_ready}, 32'h0);
        check("spur_irdata", imem_rdata, 32'h0);
        step(); memory_ready = 0;
        @(negedge clock);
        check("spur_valid", {31'b0, memory_valid}, 32'h0);

        // Ten-cycle stall with a D request arriving mid-stall
        step();
        imem_valid = 1; imem_instr = 0; imem_addr = 32'h200; imem_wdata = 32'hAABB_CCDD; imem_wstrb = 4'h3;
        for (int k = 0; k < 10; k++) begin
            step();
            imem_valid = 0;
            dmem_valid = (k == 4); dmem_instr = 0; dmem_addr = 32'h300; dmem_wstrb = 4'h0;
            @(negedge clock);
            check("stall_valid", {31'b0, memory_valid}, 32'h1);
            check("stall_addr", memory_addr, 32'h200);
            check("stall_wdata", memory_wdata, 32'hAABB_CCDD);
            check("stall_wstrb", {28'b0, memory_wstrb}, 32'h3);
        end
        step(); dmem_valid = 0; memory_ready = 1;
        @(negedge clock);
        check("stall_iready", {31'b0, imem_ready}, 32'h1);
        step(); memory_ready = 0;
        @(negedge clock);
        check("stall_next_addr", memory_addr, 32'h300);
        step(); memory_ready = 1;
        @(negedge clock);
        check("stall_dready", {31'b0, dmem_ready}, 32'h1);
        step(); memory_ready = 0;

        // Reset in the middle of an I transaction
        step(); imem_valid = 1; imem_instr = 1; imem_addr = 32'h80;
        step(); imem_valid = 0;
        @(negedge clock);
        check("abort_pre_valid", {31'b0, memory_valid}, 32'h1);
        #2 memory_ready = 1; reset = 0;
        #1;
        check("abort_valid", {31'b0, memory_valid}, 32'h0);
        check("abort_iready", {31'b0, imem_ready}, 32'h0);
        step(); memory_ready = 0;
        step(); reset = 1;
        dmem_valid = 1; dmem_instr = 0; dmem_addr = 32'h40; dmem_wstrb = 4'h0;
        step(); dmem_valid = 0;
        @(negedge clock);
        check("abort_d_valid", {31'b0, memory_valid}, 32'h1);
        check("abort_d_addr", memory_addr, 32'h40);
        step(); memory_ready = 1;
        @(negedge clock);
        check("abort_d_ready", {31'b0, dmem_ready}, 32'h1);
        step(); clear_inputs();

        // Randomised traffic with occasional asynchronous resets
        outst[0] = 0; outst[1] = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            step();
            for (int p = 0; p < 2; p++) begin
                if (!outst[p] && ($urandom_range(0, 2) == 0)) begin
                    rand_port(p, 1'b1);
                    outst[p] = 1;
                end else begin
                    rand_port(p, outst[p] && ($urandom_range(0, 49) == 0));
                end
            end
            memory_ready = ($urandom_range(0, 2) == 0);
            memory_rdata = $urandom;
            if (cyc % 800 == 400) begin
                #2 reset = 0;
                #1;
                check("rr_valid", {31'b0, memory_valid}, 32'h0);
                check("rr_iready", {31'b0, imem_ready}, 32'h0);
                check("rr_dready", {31'b0, dmem_ready}, 32'h0);
                for (int k = 0; k < 2; k++) begin
                    step();
                    rand_port(0, 1'($urandom));
                    rand_port(1, 1'($urandom));
                end
                step(); reset = 1;
                clear_inputs();
                outst[0] = 0; outst[1] = 0;
            end
            @(negedge clock);
            for (int p = 0; p < 2; p++)
                if (exp_ready(p)) outst[p] = 0;
        end

        step(); clear_inputs();
        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed: 32-bit address and data, 4-bit write strobe.
REQ-002 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 imem_valid/imem_instr/imem_addr/imem_wdata/imem_wstrb  in  1/1/32/32/4  fetch-side request.
REQ-005 imem_rdata/imem_ready  out  32/1  fetch-side response.
REQ-006 dmem_valid/dmem_instr/dmem_addr/dmem_wdata/dmem_wstrb  in  1/1/32/32/4  data-side request.
REQ-007 dmem_rdata/dmem_ready  out  32/1  data-side response.
REQ-008 memory_valid/memory_instr/memory_addr/memory_wdata/memory_wstrb  out  1/1/32/32/4  shared memory port request.
REQ-009 memory_rdata/memory_ready  in  32/1  shared memory port response.

Function
REQ-010 The block SHALL share one memory port between two requesters (I = imem, D = dmem) with one transaction in flight at a time.
REQ-011 A requester SHALL issue a request as a 1-cycle valid pulse, with all request fields valid in that cycle.
REQ-012 A requester SHALL NOT issue a new request before its previous ready; a valid on a port whose request is pending or granted SHALL be ignored.
REQ-013 The FSM SHALL have exactly three states: IDLE, GRANT_I, GRANT_D.
REQ-014 Each port SHALL have a one-entry pending register (flag, instr, addr, wdata, wstrb).
- A valid not granted in its arrival cycle SHALL be captured there.
REQ-015 In IDLE, the candidates SHALL be pending OR incoming valid, per port.
- One candidate: go to its GRANT state at the next edge.
- Both candidates: grant the port NOT equal to last_grant; capture the loser into its pending register.
REQ-016 On entry to GRANT_x, memory_* outputs SHALL be registered copies of x's request fields, with memory_valid=1.
- Latency from request valid (cycle 0, IDLE) to memory_valid SHALL be 1 cycle.
REQ-017 In GRANT_x, memory_valid and all memory_* fields SHALL remain high and stable until memory_ready=1.
REQ-018 x_ready SHALL equal memory_ready AND (state==GRANT_x), combinationally.
- x_rdata SHALL equal memory_rdata when state==GRANT_x, else 32'h0.
- The non-granted port's ready SHALL be 0.
REQ-019 On the edge where memory_ready=1 in GRANT_x:
- last_grant SHALL be set to x.
- If the other port has a pending request or an incoming valid, go directly to GRANT_other; memory_valid stays 1 and the new fields load (back-to-back, no bubble).
- Otherwise go to IDLE, with memory_valid=0 and memory_addr/wdata/wstrb/instr=0.
REQ-020 A request arriving on the other port during GRANT_x SHALL be captured into pending, then served per REQ-019.
REQ-021 memory_ready asserted in IDLE SHALL be ignored and produce no requester ready.
REQ-022 Fairness: any request SHALL reach memory_valid after at most one completed transaction of the other port.
REQ-023 The pending flag SHALL clear on the edge its request is granted.
REQ-024 Write vs read SHALL be signalled by wstrb only (wstrb != 0 means write).
- wdata/wstrb SHALL pass unmodified; the block does no data alignment.

Reset
REQ-025 While reset=0, the block SHALL hold, immediately (asynchronously):
- state=IDLE, both pending flags=0, last_grant=I (so D wins the first tie);
- memory_valid=0, memory_instr=0, memory_addr=0, memory_wdata=0, memory_wstrb=0.
REQ-026 Reset asserted mid-transaction SHALL abort it: memory_valid drops asynchronously and no ready is delivered to either requester.
REQ-027 Requests presented while reset=0 SHALL be discarded.
REQ-028 After reset release, the first request SHALL be accepted on the first rising edge with reset=1.

Verification
REQ-029 Single read: I valid, addr=0x0000_0100, wstrb=0; memory_ready 2 cycles after memory_valid with rdata=0xDEAD_BEEF -> memory_valid at cycle 1 with addr 0x100, instr=1; imem_ready=1 with rdata=0xDEADBEEF at cycle 3; dmem_ready=0 throughout.
REQ-030 Simultaneous requests after reset: I addr=0x10, D addr=0x20 wstrb=0xF wdata=0x1234_5678 -> D granted first (memory_addr=0x20, wstrb=0xF); on its ready, back-to-back memory_valid with addr=0x10 the next cycle, no bubble.
REQ-031 Round-robin: D keeps re-requesting 1 cycle after each dmem_ready while I requests once -> I is granted immediately after the first D completion; no port is served twice in a row while the other waits.
REQ-032 Stall hold: memory_ready held 0 for 10 cycles -> memory_* fields unchanged for all 10 cycles; a D request arriving mid-stall is served right after.
REQ-033 Reset mid-transaction: reset=0 while in GRANT_I -> memory_valid=0 in the same cycle, no imem_ready; after release, a new D request addr=0x40 is issued with 1-cycle latency.
REQ-034 Spurious memory_ready=1 in IDLE -> both ready outputs 0 and the state stays IDLE.
